// File: rtl/pll_ctrl_pkg.sv
// Shared types, default constants and the slew helper for the pll_ctrl supervisor.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SLEW    = 2'd1,
    ST_BRAKE   = 2'd2,
    ST_LOCKOUT = 2'd3
  } pll_ctrl_state_e;

  localparam int DEF_DIVN_RESET           = 10;
  localparam int DEF_DIVN_MIN             = 4;
  localparam int DEF_DIVN_MAX             = 1000;
  localparam int DEF_DIVN_STEP            = 1;
  localparam int DEF_STEP_HOLD_CYCLES     = 32;
  localparam int DEF_BRAKE_PULSE_CYCLES   = 4;
  localparam int DEF_BRAKE_LOCKOUT_CYCLES = 600;

  // Shared timer width; must hold the largest of the hold/pulse/lockout reloads.
  localparam int TMR_W = 16;

  // One rate-limited move of cur toward tgt, signed so both directions work.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input int          step);
    int diff;
    diff = $signed(tgt) - $signed(cur);
    if (diff > step)       return cur + step;
    else if (diff < -step) return cur - step;
    else                   return tgt;
  endfunction

endpackage

// File: rtl/pll_ctrl_timer.sv
// Loadable down-counter with a terminal-count flag, shared by all pll_ctrl states.
module pll_ctrl_timer
  import pll_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               cnt_q <= '0;
    else if (load_i)            cnt_q <= load_val_i;
    else if (cnt_q != '0)       cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pll_ctrl.sv
// Refclk-domain PLL divider slew/brake supervisor.
// Optional statistics counters are enabled by defining PLL_CTRL_STATS_EN.
//
// state   | meaning
// IDLE    | divn == target, requests accepted
// SLEW    | stepping divn toward target every STEP_HOLD_CYCLES
// BRAKE   | brake pulse active, divn frozen
// LOCKOUT | PLL recovering, divn frozen, droop edges ignored
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int DIVN_RESET           = DEF_DIVN_RESET,
  parameter int DIVN_MIN             = DEF_DIVN_MIN,
  parameter int DIVN_MAX             = DEF_DIVN_MAX,
  parameter int DIVN_STEP            = DEF_DIVN_STEP,
  parameter int STEP_HOLD_CYCLES     = DEF_STEP_HOLD_CYCLES,
  parameter int BRAKE_PULSE_CYCLES   = DEF_BRAKE_PULSE_CYCLES,
  parameter int BRAKE_LOCKOUT_CYCLES = DEF_BRAKE_LOCKOUT_CYCLES
) (
  input  logic        refclk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_divn,
  input  logic        droop,
  output logic [31:0] divn,
  output logic        brake,
  output logic        busy,
`ifdef PLL_CTRL_STATS_EN
  output logic [15:0] brake_count,
  output logic [15:0] droop_ignored,
`endif
  output logic        range_err
);

  localparam logic [TMR_W-1:0] HOLD_LD    = TMR_W'(STEP_HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LD   = TMR_W'(BRAKE_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LD = TMR_W'(BRAKE_LOCKOUT_CYCLES - 1);

  pll_ctrl_state_e state_q, state_d;
  logic [31:0] divn_q, divn_d, target_q, target_d;
  logic        brake_q, brake_d, range_err_q, range_err_d, droop_q;
  logic        droop_rise, tmr_load, tmr_done, brake_evt, droop_ign_evt, req_bad;
  logic [TMR_W-1:0] tmr_val;

  assign droop_rise = droop && !droop_q;
  assign req_bad    = ($signed(req_divn) < DIVN_MIN) || ($signed(req_divn) > DIVN_MAX);

  pll_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk_i      (refclk),
    .rst_n_i    (resetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      divn_q      <= 32'(DIVN_RESET);
      target_q    <= 32'(DIVN_RESET);
      brake_q     <= 1'b0;
      range_err_q <= 1'b0;
      droop_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      divn_q      <= divn_d;
      target_q    <= target_d;
      brake_q     <= brake_d;
      range_err_q <= range_err_d;
      droop_q     <= droop;
    end
  end

  always_comb begin
    state_d       = state_q;
    divn_d        = divn_q;
    target_d      = target_q;
    range_err_d   = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    brake_evt     = 1'b0;
    droop_ign_evt = 1'b0;
    req_ready     = (state_q == ST_IDLE) && !droop_rise;

    case (state_q)
      ST_IDLE: begin
        if (droop_rise) begin
          state_d   = ST_BRAKE;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LD;
          brake_evt = 1'b1;
        end else if (req_valid) begin
          if (req_bad) begin
            range_err_d = 1'b1;
          end else if (req_divn != divn_q) begin
            target_d = req_divn;
            state_d  = ST_SLEW;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end
        end
      end
      ST_SLEW: begin
        if (droop_rise) begin
          state_d   = ST_BRAKE;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LD;
          brake_evt = 1'b1;
        end else if (tmr_done) begin
          divn_d   = step_toward(divn_q, target_q, DIVN_STEP);
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          if (divn_d == target_q) state_d = ST_IDLE;
        end
      end
      ST_BRAKE: begin
        if (tmr_done) begin
          state_d  = ST_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = LOCKOUT_LD;
        end
      end
      ST_LOCKOUT: begin
        droop_ign_evt = droop_rise;
        if (tmr_done) begin
          if (divn_q != target_q) begin
            state_d  = ST_SLEW;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    brake_d = (state_d == ST_BRAKE);
  end

  assign divn      = divn_q;
  assign brake     = brake_q;
  assign busy      = (state_q != ST_IDLE);
  assign range_err = range_err_q;

`ifdef PLL_CTRL_STATS_EN
  logic [15:0] brake_cnt_q, droop_ign_q;

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      brake_cnt_q <= '0;
      droop_ign_q <= '0;
    end else begin
      if (brake_evt && brake_cnt_q != 16'hFFFF)     brake_cnt_q <= brake_cnt_q + 1'b1;
      if (droop_ign_evt && droop_ign_q != 16'hFFFF) droop_ign_q <= droop_ign_q + 1'b1;
    end
  end

  assign brake_count   = brake_cnt_q;
  assign droop_ignored = droop_ign_q;
`endif

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: slew timing, range rejection, brake/lockout and async reset.
module tb_pll_ctrl;

  logic        refclk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_divn;
  logic        droop;
  logic [31:0] divn;
  logic        brake;
  logic        busy;
  logic        range_err;
`ifdef PLL_CTRL_STATS_EN
  logic [15:0] brake_count;
  logic [15:0] droop_ignored;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m;

  pll_ctrl dut (
    .refclk    (refclk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_divn  (req_divn),
    .droop     (droop),
    .divn      (divn),
    .brake     (brake),
    .busy      (busy),
`ifdef PLL_CTRL_STATS_EN
    .brake_count   (brake_count),
    .droop_ignored (droop_ignored),
`endif
    .range_err (range_err)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_divn  = '0;
    droop     = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic request(input int val);
    req_valid = 1'b1;
    req_divn  = val;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_divn", divn, 10);
    chk("rst_brake", {31'b0, brake}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_range_err", {31'b0, range_err}, 0);
    chk("rst_ready", {31'b0, req_ready}, 1);
`ifdef PLL_CTRL_STATS_EN
    chk("rst_brake_count", {16'b0, brake_count}, 0);
`endif

    // out-of-range requests, above and below, then a no-op
    request(2000);
    chk("hi_range_err", {31'b0, range_err}, 1);
    chk("hi_divn", divn, 10);
    chk("hi_busy", {31'b0, busy}, 0);
    tick();
    chk("hi_range_err_1cyc", {31'b0, range_err}, 0);
    request(3);
    chk("lo_range_err", {31'b0, range_err}, 1);
    request(-5);
    chk("neg_range_err", {31'b0, range_err}, 1);
    request(1001);
    chk("max1_range_err", {31'b0, range_err}, 1);
    request(10);
    chk("noop_busy", {31'b0, busy}, 0);
    chk("noop_range_err", {31'b0, range_err}, 0);

    // slew 10 -> 14, one step per 32 cycles
    request(14);
    m = cyc;
    chk("slew_busy", {31'b0, busy}, 1);
    chk("slew_ready", {31'b0, req_ready}, 0);
    for (int k = 1; k <= 4; k++) begin
      run_to(m + 32*k - 1);
      chk("slew_before_step", divn, 10 + k - 1);
      tick();
      chk("slew_step", divn, 10 + k);
    end
    chk("slew_done_busy", {31'b0, busy}, 0);
    chk("slew_done_ready", {31'b0, req_ready}, 1);

    // downward slew by one step
    request(13);
    run_to(m + 128 + 1 + 32);
    chk("down_step", divn, 13);
    chk("down_busy", {31'b0, busy}, 0);

    // slew 10 -> 20 with droop at step 13, second droop during lockout
    do_reset();
    request(20);
    m = cyc;
    run_to(m + 96);
    chk("pre_droop_divn", divn, 13);
    run_to(m + 100);
    droop = 1'b1;
    tick();
    m = cyc;
    droop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("brake_high", {31'b0, brake}, 1);
      tick();
    end
    chk("brake_low", {31'b0, brake}, 0);
    chk("lock_busy", {31'b0, busy}, 1);
    run_to(m + 200);
    droop = 1'b1;
    tick();
    droop = 1'b0;
    chk("lock_no_brake", {31'b0, brake}, 0);
    tick();
    chk("lock_no_brake2", {31'b0, brake}, 0);
    run_to(m + 635);
    chk("lock_frozen", divn, 13);
    tick();
    chk("post_lock_step", divn, 14);
    run_to(m + 636 + 6*32 - 1);
    chk("post_lock_19", divn, 19);
    tick();
    chk("post_lock_20", divn, 20);
    chk("post_lock_idle", {31'b0, busy}, 0);
`ifdef PLL_CTRL_STATS_EN
    chk("stat_brake_count", {16'b0, brake_count}, 1);
    chk("stat_droop_ignored", {16'b0, droop_ignored}, 1);
`endif

    // request and droop edge in the same IDLE cycle
    req_valid = 1'b1;
    req_divn  = 15;
    droop     = 1'b1;
    #1;
    chk("coinc_ready", {31'b0, req_ready}, 0);
    tick();
    m = cyc;
    droop = 1'b0;
    chk("coinc_brake", {31'b0, brake}, 1);
    chk("coinc_divn", divn, 20);
    run_to(m + 603);
    chk("coinc_lock_busy", {31'b0, busy}, 1);
    chk("coinc_lock_ready", {31'b0, req_ready}, 0);
    tick();
    chk("coinc_idle", {31'b0, busy}, 0);
    chk("coinc_idle_ready", {31'b0, req_ready}, 1);
    tick();
    req_valid = 1'b0;
    chk("coinc_accepted", {31'b0, busy}, 1);
    run_to(m + 605 + 31);
    chk("coinc_pre_step", divn, 20);
    tick();
    chk("coinc_step", divn, 19);

    // async reset in the second brake cycle
    do_reset();
    request(11);
    run_to(cyc + 32);
    chk("pre_rst_divn", divn, 11);
    droop = 1'b1;
    tick();
    tick();
    chk("rst2_brake_before", {31'b0, brake}, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst2_brake", {31'b0, brake}, 0);
    chk("rst2_divn", divn, 10);
    chk("rst2_busy", {31'b0, busy}, 0);
    droop = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    chk("rst2_ready", {31'b0, req_ready}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
